// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl
// Accepts a parallel word on a valid/ready input, shifts it MSB-first through
// a window matcher one bit per cycle, counts overlapping matches of a
// runtime-programmable pattern, and presents a summary (count, found flag,
// index of the bit completing the first match) on a valid/ready output.
// Cycle numbering: the accept edge is cycle 0, and SHIFT cycle k handles bit
// word[DATA_W-1-k]. A match in cycle k pulses match_pulse in cycle k+1. The
// result becomes valid one cycle after entering REPORT.

module pattern_scan_ctrl #(
    parameter int DATA_W = 16,
    parameter int PAT_W  = 8,
    parameter int CNT_W  = $clog2(DATA_W + 1),
    parameter int IDX_W  = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cfg_we,
    input  logic [PAT_W-1:0]  cfg_pattern,
    input  logic [3:0]        cfg_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              abort,
    output logic              match_pulse,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_found,
    output logic [IDX_W-1:0]  out_first_idx
);

    // Width that can hold any legal pattern length 1..PAT_W.
    localparam int LEN_W = $clog2(PAT_W + 1);
    // Width used to compare "bits seen so far" (k+1, up to DATA_W) with the length.
    localparam int CMP_W = IDX_W + 1;

    localparam int                RST_LEN_I   = (PAT_W < 4) ? PAT_W : 4;
    localparam logic [PAT_W-1:0]  RST_PATTERN = PAT_W'(8'b0000_1010);
    localparam logic [LEN_W-1:0]  RST_LEN     = LEN_W'(RST_LEN_I);
    localparam logic [IDX_W-1:0]  K_LAST      = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0]  K_ONE       = IDX_W'(1'b1);
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1'b1);
    localparam logic [CMP_W-1:0]  CMP_ONE     = CMP_W'(1'b1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_REPORT = 2'd2
    } state_e;

    // Registered state
    state_e             state_q;
    logic [PAT_W-1:0]   pattern_q;
    logic [LEN_W-1:0]   len_q;
    logic [DATA_W-1:0]  word_q;      // remaining bits, next bit always at the MSB
    logic [PAT_W-1:0]   hist_q;      // bit 0 = most recently shifted bit
    logic [IDX_W-1:0]   k_q;
    logic [CNT_W-1:0]   count_q;
    logic [IDX_W-1:0]   first_idx_q;
    logic               found_q;
    logic               in_ready_q;
    logic               busy_q;
    logic               out_valid_q;
    logic               match_pulse_q;

    // Combinational next values
    logic [LEN_W-1:0]   cfg_len_d;
    logic               bit_d;
    logic [PAT_W-1:0]   hist_d;
    logic [PAT_W-1:0]   mask_d;
    logic [CMP_W-1:0]   seen_d;
    logic               match_d;
    logic               last_bit_d;

    // Normalise the requested pattern length into 1..PAT_W.
    always_comb begin
        cfg_len_d = LEN_W'(1'b1);
        if (cfg_len == 4'd0) begin
            cfg_len_d = LEN_W'(1'b1);
        end else if (int'(cfg_len) > PAT_W) begin
            cfg_len_d = LEN_W'(PAT_W);
        end else begin
            cfg_len_d = LEN_W'(cfg_len);
        end
    end

    // Window matcher: shift in the next bit and compare the low len bits.
    always_comb begin
        bit_d  = word_q[DATA_W-1];
        hist_d = {hist_q[PAT_W-2:0], bit_d};
        mask_d = {PAT_W{1'b0}};
        for (int i = 0; i < PAT_W; i++) begin
            mask_d[i] = (LEN_W'(i) < len_q);
        end
        // A full window exists only once at least len bits of this word were seen.
        seen_d     = {1'b0, k_q} + CMP_ONE;
        match_d    = (seen_d >= CMP_W'(len_q)) &&
                     ((hist_d & mask_d) == (pattern_q & mask_d));
        last_bit_d = (k_q == K_LAST);
    end

    // Control FSM with all datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            pattern_q     <= RST_PATTERN;
            len_q         <= RST_LEN;
            word_q        <= {DATA_W{1'b0}};
            hist_q        <= {PAT_W{1'b0}};
            k_q           <= {IDX_W{1'b0}};
            count_q       <= {CNT_W{1'b0}};
            first_idx_q   <= {IDX_W{1'b0}};
            found_q       <= 1'b0;
            in_ready_q    <= 1'b1;
            busy_q        <= 1'b0;
            out_valid_q   <= 1'b0;
            match_pulse_q <= 1'b0;
        end else begin
            match_pulse_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // Configuration writes land at the same edge as an accept,
                    // so a word accepted together with cfg_we sees the new setup.
                    if (cfg_we) begin
                        pattern_q <= cfg_pattern;
                        len_q     <= cfg_len_d;
                    end else begin
                        pattern_q <= pattern_q;
                    end
                    if (in_valid && in_ready_q) begin
                        word_q      <= in_data;
                        hist_q      <= {PAT_W{1'b0}};
                        k_q         <= {IDX_W{1'b0}};
                        count_q     <= {CNT_W{1'b0}};
                        first_idx_q <= {IDX_W{1'b0}};
                        found_q     <= 1'b0;
                        in_ready_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= ST_SHIFT;
                    end else begin
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end

                ST_SHIFT: begin
                    if (abort) begin
                        state_q    <= ST_IDLE;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end else begin
                        word_q <= {word_q[DATA_W-2:0], 1'b0};
                        hist_q <= hist_d;
                        k_q    <= k_q + K_ONE;
                        if (match_d) begin
                            count_q       <= count_q + CNT_ONE;
                            found_q       <= 1'b1;
                            match_pulse_q <= 1'b1;
                            if (count_q == {CNT_W{1'b0}}) begin
                                first_idx_q <= k_q;
                            end else begin
                                first_idx_q <= first_idx_q;
                            end
                        end else begin
                            count_q <= count_q;
                        end
                        if (last_bit_d) begin
                            state_q <= ST_REPORT;
                        end else begin
                            state_q <= ST_SHIFT;
                        end
                    end
                end

                ST_REPORT: begin
                    // abort wins over a same-cycle result handshake.
                    if (abort) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end else if (out_valid_q && out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end

                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready      = in_ready_q;
    assign busy          = busy_q;
    assign out_valid     = out_valid_q;
    assign match_pulse   = match_pulse_q;
    assign out_count     = count_q;
    assign out_found     = found_q;
    assign out_first_idx = first_idx_q;

endmodule

// File: doc/pattern_scan_ctrl.md
Name: pattern_scan_ctrl

Overview:
- Controller that sequences a programmable, overlapping serial pattern detector over parallel words.
- Accepts a DATA_W-bit word on a valid/ready input and shifts it MSB-first through an internal window matcher, one bit per cycle.
- Counts matches and returns a summary (count, found flag, first-match index) on a valid/ready output.
- Sits between a word-oriented producer and bit-serial detection logic; the pattern and its length are configured at runtime.

Parameters:
- DATA_W, 16, bits per scanned word (>=2).
- PAT_W, 8, maximum pattern length in bits (2..DATA_W).
- CNT_W, $clog2(DATA_W+1), width of match count.
- IDX_W, $clog2(DATA_W), width of bit-index fields.

Ports:
- clk  input  1  clock, all logic on rising edge.
- resetn  input  1  synchronous, active-low reset.
- cfg_we  input  1  configuration write strobe.
- cfg_pattern  input  PAT_W  pattern; bit 0 = most recently received bit.
- cfg_len  input  4  pattern length in bits.
- in_valid  input  1  word available.
- in_ready  output  1  controller can accept a word.
- in_data  input  DATA_W  word to scan, MSB shifted first.
- abort  input  1  cancel the current scan.
- match_pulse  output  1  one-cycle pulse per match.
- busy  output  1  high in SHIFT or REPORT.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_count  output  CNT_W  number of matches in the word.
- out_found  output  1  out_count != 0.
- out_first_idx  output  IDX_W  bit index k completing the first match; 0 if none.

Behaviour:
- Reset values (resetn low at a clock edge): state IDLE; in_ready=1, busy=0, out_valid=0, match_pulse=0, out_count=0, out_found=0, out_first_idx=0; pattern=8'b0000_1010, len=4; history, bit index and count cleared.
- Reset mid-scan or mid-report returns to IDLE. Any pending result is discarded.
- The FSM has three states: IDLE, SHIFT, REPORT.
  - In IDLE, in_ready=1.
  - in_valid&&in_ready latches in_data, clears history, bit index k, count and first-index, then enters SHIFT.
- Configuration:
  - cfg_we is honoured only in IDLE and ignored when busy.
  - cfg_len=0 is treated as 1. cfg_len>PAT_W is clamped to PAT_W.
  - If cfg_we and an input handshake occur in the same IDLE cycle, the new configuration applies to that word.
- SHIFT, one bit per cycle:
  - In SHIFT cycle k (k=0..DATA_W-1), bit b=word[DATA_W-1-k]; hist_next={hist[PAT_W-2:0],b}.
  - A match occurs when k+1>=len and hist_next[len-1:0]==pattern[len-1:0]. Overlapping matches count.
  - History is per word; it never spans words.
- On a match in cycle k:
  - count increments.
  - If count was 0, first_idx<=k.
  - match_pulse is high in cycle k+1 (registered, one-cycle latency).
- After k=DATA_W-1, the FSM goes to REPORT.
- REPORT:
  - out_valid=1, and the outputs are stable while out_ready=0.
  - The match_pulse for the last bit coincides with the first REPORT cycle, and out_count already includes it.
  - out_valid&&out_ready returns to IDLE; in_ready is high the following cycle.
- Latency: with the accept edge as cycle 0, out_valid rises in cycle DATA_W+1 (cycle 17 at the default). Throughput is at most one word per DATA_W+2 cycles.
- Abort:
  - abort in SHIFT or REPORT returns to IDLE at the next edge. No out_valid for that word, and match_pulse is suppressed from then on.
  - abort in IDLE is ignored, and a same-cycle handshake proceeds.
  - abort has priority over out_ready in REPORT.
- out_count cannot overflow: the maximum is DATA_W-len+1.
- in_ready=0 whenever busy=1. No word is accepted during SHIFT or REPORT.

Test Plan:
- Default config (1010, len 4), in_data=16'hAAAA, out_ready=1 -> match_pulse in cycles 4,6,...,16; out_count=7, out_found=1, out_first_idx=3; out_valid in cycle 17.
- in_data=16'h0000 with default config -> no match_pulse; out_count=0, out_found=0, out_first_idx=0.
- cfg_we with pattern=8'hFF, len=8 in IDLE, then in_data=16'hFFFF -> out_count=9, out_first_idx=7. A cfg_we issued during SHIFT is ignored, and the next word still uses 8'hFF.
- Hold out_ready=0 for 5 cycles in REPORT -> out_valid and result fields stable, in_ready=0, busy=1. Raising out_ready -> IDLE, and in_ready=1 the next cycle.
- Assert abort at k=6 while scanning 16'hAAAA -> busy=0 and in_ready=1 the next cycle, no out_valid. The next word 16'h000A yields out_count=1, out_first_idx=15 (no stale history).
- Deassert resetn at k=10 -> all outputs reach their reset values after the edge, and the configuration returns to 1010/len 4.
